// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch unit with a small decoupling buffer.
//
// Issues one instruction-memory request at a time for the address supplied by
// the program counter, pushes each returned word (with its address) into a
// FIFO that feeds decode, and pulses `step` so the PC advances by 4. A flush
// empties the FIFO immediately. A request that is already in flight when the
// flush arrives is completed on the memory side, and its data is discarded.
//
// Configuration macro:
//   IF_PREFETCH_BUF_EN  defined   -> DEPTH=2 (one instruction can wait for
//                                    decode while the next fetch is in flight)
//                       undefined -> DEPTH=1 (single instruction register)
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   inst_addr   [31:0] fetch address from the program counter
//   flush              redirect: drop buffered and in-flight instructions
//   step               one-cycle pulse: advance the PC by 4
//   imem_req           memory request, held until imem_ack
//   imem_addr   [31:0] request address
//   imem_ack           memory returns imem_rdata this cycle
//   imem_rdata  [31:0] returned instruction word
//   id_ready           decode takes the head instruction this cycle
//   inst_valid         head instruction valid
//   inst        [31:0] head instruction word (NOP when the buffer is empty)
//   inst_pc     [31:0] head instruction address (0 when the buffer is empty)
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  input  logic        flush,
  output logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

`ifdef IF_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Storage is rounded up to a power of two so the pointer index always fits.
  localparam int SLOTS = 1 << PTR_W;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_inst_q [SLOTS];
  logic [31:0]      fifo_pc_q   [SLOTS];
  logic             push;
  logic             pop;
  logic             not_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign not_full   = (count_q < CNT_W'(DEPTH));
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && id_ready && !flush;
  assign imem_addr  = addr_q;
  assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : NOP;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;

  // Fetch FSM: next state, request and step generation
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    imem_req = 1'b0;
    step     = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Requests only issue with a free slot, so a push can never overflow.
        if (!flush && not_full) begin
          state_d = REQ;
          addr_d  = inst_addr;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = IDLE;
          if (!flush) begin
            push = 1'b1;
            step = 1'b1;
          end
        end else if (flush) begin
          // The memory still owes us a response; absorb it in DRAIN.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer bookkeeping: flush wins over any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage; contents are qualified by count_q, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

`ifdef IF_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        flush;
  logic        step;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .inst_addr (inst_addr),
    .flush     (flush),
    .step      (step),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_ready  (id_ready),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        fl;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_step;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Reference model: a queue of buffered instructions plus one outstanding
  // memory transaction that is either wanted or marked for discard.
  ent_t        mq[$];
  bit          m_pend;
  bit          m_disc;
  logic [31:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [31:0] a, input logic ak, input logic [31:0] rd,
                     input logic fl, input logic rdy);
    inst_addr  = a;
    imem_ack   = ak;
    imem_rdata = rd;
    flush      = fl;
    id_ready   = rdy;
  endtask

  // Reset and leave flush high so the DUT stays idle until the next drive.
  task automatic do_reset();
    @(negedge clk);
    drv(32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_pend = 1'b0;
    m_disc = 1'b0;
    m_addr = 32'h0;
  endtask

  task automatic model_step(input logic fl, input logic ak, input logic rdy,
                            input logic [31:0] a, input logic [31:0] rd);
    bit do_push;
    int n;
    ent_t e;
    do_push = m_pend && !m_disc && ak && !fl;
    n = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (n != 0 && rdy) void'(mq.pop_front());
      if (do_push) begin
        e.inst = rd;
        e.pc   = m_addr;
        mq.push_back(e);
      end
    end
    if (!m_pend) begin
      if (!fl && n < DEPTH) begin
        m_pend = 1'b1;
        m_disc = 1'b0;
        m_addr = a;
      end
    end else if (ak) begin
      m_pend = 1'b0;
    end else if (fl) begin
      m_disc = 1'b1;
    end
  endtask

  vec_t tbl[16];

  initial begin
    logic [31:0] pc;
    logic [31:0] a, rd;
    logic        ak, fl, rdy;
    int          bias;
    bit          e_step;

    tbl[0]  = '{32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[1]  = '{32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[2]  = '{32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[3]  = '{32'h44,  1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[4]  = '{32'h44,  1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 1'b0, NOP,          32'h0};
    tbl[5]  = '{32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00500093, 32'h0};
    tbl[6]  = '{32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[7]  = '{32'h0,   1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, NOP,          32'h0};
    tbl[8]  = '{32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF, 32'h100};
    tbl[9]  = '{32'h200, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[10] = '{32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, NOP,          32'h0};
    tbl[11] = '{32'h300, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, NOP,          32'h0};
    tbl[12] = '{32'h300, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, NOP,          32'h0};
    tbl[13] = '{32'h300, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, NOP,          32'h0};
    tbl[14] = '{32'h0,   1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, NOP,          32'h0};
    tbl[15] = '{32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h22222222, 32'h300};

    // Reset state
    rst = 1'b1;
    drv(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   32'(imem_req),   32'h0);
    chk("rst_step",  32'(step),       32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst",  inst,            NOP);
    chk("rst_pc",    inst_pc,         32'h0);
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: basic fetch, delayed ack, flush in REQ / DRAIN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drv(tbl[i].addr, tbl[i].ack, tbl[i].rdata, tbl[i].fl, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_req", i),   32'(imem_req),   32'(tbl[i].e_req));
      chk($sformatf("v%0d_step", i),  32'(step),       32'(tbl[i].e_step));
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_inst", i), inst,    tbl[i].e_inst);
        chk($sformatf("v%0d_pc", i),   inst_pc, tbl[i].e_pc);
      end
    end

    // Decode stalled: buffer fills to DEPTH, fetching stops, then drains in order
    do_reset();
    pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drv(pc, 1'b1, 32'hA0000000 | pc, 1'b0, 1'b0);
      #1;
      if (step) pc = pc + 32'd4;
    end
    @(negedge clk);
    drv(pc, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stall_steps", pc, 32'(4 * DEPTH));
    chk("stall_req",   32'(imem_req),   32'h0);
    chk("stall_valid", 32'(inst_valid), 32'h1);
    chk("stall_pc0",   inst_pc,         32'h0);
    chk("stall_inst0", inst,            32'hA0000000);
    @(negedge clk);
    drv(pc, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("pop_pc0", inst_pc, 32'h0);
    @(negedge clk);
    drv(pc, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
`ifdef IF_PREFETCH_BUF_EN
    chk("pop_valid1", 32'(inst_valid), 32'h1);
    chk("pop_pc1",    inst_pc,         32'h4);
    chk("pop_inst1",  inst,            32'hA0000004);
`else
    chk("pop_valid1", 32'(inst_valid), 32'h0);
`endif

    // Flush together with ack while the buffer holds an instruction
    do_reset();
    @(negedge clk); drv(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); drv(32'h0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0); #1;
    chk("fa_step_push", 32'(step), 32'h1);
    @(negedge clk); drv(32'h44, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("fa_valid_pre", 32'(inst_valid), 32'h1);
    @(negedge clk); drv(32'h0, 1'b1, 32'h12345678, 1'b1, 1'b0); #1;
    chk("fa_step", 32'(step), 32'h0);
    chk("fa_valid_same", 32'(inst_valid), 32'h1);
    @(negedge clk); drv(32'h80, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("fa_valid_next", 32'(inst_valid), 32'h0);
    chk("fa_req_idle",   32'(imem_req),   32'h0);
    @(negedge clk); drv(32'h0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("fa_req_new",  32'(imem_req), 32'h1);
    chk("fa_addr_new", imem_addr,     32'h80);

    // Asynchronous reset in the middle of a request; late ack ignored
    do_reset();
    @(negedge clk); drv(32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); drv(32'h0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("ar_req_before", 32'(imem_req), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("ar_req",   32'(imem_req),   32'h0);
    chk("ar_step",  32'(step),       32'h0);
    chk("ar_valid", 32'(inst_valid), 32'h0);
    chk("ar_inst",  inst,            NOP);
    chk("ar_pc",    inst_pc,         32'h0);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("late_ack_step", 32'(step), 32'h0);
    @(negedge clk); drv(32'h0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("late_ack_valid", 32'(inst_valid), 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    bias = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = (bias == 80) ? 15 : 80;
      a   = $urandom & 32'hFFFFFFFC;
      rd  = $urandom;
      ak  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 99) < bias);
      @(negedge clk);
      drv(a, ak, rd, fl, rdy);
      #1;
      e_step = m_pend && !m_disc && ak && !fl;
      chk("rnd_req",   32'(imem_req),   32'(m_pend));
      chk("rnd_step",  32'(step),       32'(e_step));
      chk("rnd_valid", 32'(inst_valid), 32'(mq.size() != 0));
      if (m_pend) chk("rnd_addr", imem_addr, m_addr);
      if (mq.size() != 0) begin
        chk("rnd_inst", inst,    mq[0].inst);
        chk("rnd_pc",   inst_pc, mq[0].pc);
      end
      model_step(fl, ak, rdy, a, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
